// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter.
//   - arb_state_e : arbiter FSM state encoding
//   - REQ_WRITE / REQ_PWB : values of a requester's bus_req_type bit
//   - BUS_WIDTH : width of the shared system bus
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_TURN = 2'd2
    } arb_state_e;

    localparam logic REQ_WRITE = 1'b0;
    localparam logic REQ_PWB   = 1'b1;

    localparam int unsigned BUS_WIDTH = 38;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker (purely combinational).
//   req    : request vector, one bit per agent
//   rr_ptr : index of the last winner; scanning starts at rr_ptr+1
//   valid  : at least one request bit is set
//   winner : first set bit found scanning upward from rr_ptr+1, modulo NUM_REQ
module rr_picker #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                valid,
    output logic [ID_WIDTH-1:0] winner
);

    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_WIDTH'((32'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared system bus.
//   plusclk      : clock, rising edge
//   rst          : synchronous active-high reset
//   bus_req      : per-agent request level
//   bus_req_type : per-agent request class (REQ_WRITE / REQ_PWB)
//   bus_hold     : per-agent tenure hold; only the owner's bit is observed
//   bus_grant    : registered one-hot ownership
//   bus_active   : registered, high whenever any grant is high
//   owner_id     : index of the current owner, 0 when idle
//   timeout_err  : one-cycle pulse in the TURN cycle after a forced release
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic                plusclk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  bus_req,
    input  logic [NUM_REQ-1:0]  bus_req_type,
    input  logic [NUM_REQ-1:0]  bus_hold,
    output logic [NUM_REQ-1:0]  bus_grant,
    output logic                bus_active,
    output logic [ID_WIDTH-1:0] owner_id,
    output logic                timeout_err
);

    localparam int unsigned         HCW      = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0]      HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [ID_WIDTH-1:0] PTR_RST  = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                active_q, active_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic                timeout_q, timeout_d;

    logic [NUM_REQ-1:0]  pwb_vec;
    logic                pwb_valid, all_valid, pick_valid;
    logic [ID_WIDTH-1:0] pwb_winner, all_winner, pick_winner;
    logic                owner_hold, hold_expired;

    always_comb begin
        pwb_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pwb_vec[i] = bus_req[i] && (bus_req_type[i] == REQ_PWB);
        end
    end

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick_pwb (
        .req    (pwb_vec),
        .rr_ptr (rr_ptr_q),
        .valid  (pwb_valid),
        .winner (pwb_winner)
    );

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick_all (
        .req    (bus_req),
        .rr_ptr (rr_ptr_q),
        .valid  (all_valid),
        .winner (all_winner)
    );

    // Any PWB request restricts the choice to the PWB class.
    assign pick_valid  = (|pwb_vec) ? pwb_valid  : all_valid;
    assign pick_winner = (|pwb_vec) ? pwb_winner : all_winner;

    assign owner_hold   = bus_hold[owner_q];
    assign hold_expired = (hold_cnt_q == HOLD_MAX);

    // State and output registers
    always_ff @(posedge plusclk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            hold_cnt_q <= '0;
            rr_ptr_q   <= PTR_RST;
            grant_q    <= '0;
            active_q   <= 1'b0;
            owner_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (pick_valid) state_d = ARB_OWN;
            ARB_OWN:  if (!owner_hold || hold_expired) state_d = ARB_TURN;
            ARB_TURN: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Output and datapath next values; everything drops to zero outside a tenure.
    always_comb begin
        grant_d    = '0;
        active_d   = 1'b0;
        owner_d    = '0;
        timeout_d  = 1'b0;
        hold_cnt_d = '0;
        rr_ptr_d   = rr_ptr_q;
        if (state_q == ARB_IDLE && pick_valid) begin
            grant_d    = NUM_REQ'(1) << pick_winner;
            active_d   = 1'b1;
            owner_d    = pick_winner;
            hold_cnt_d = HCW'(1);
            rr_ptr_d   = pick_winner;
        end else if (state_q == ARB_OWN) begin
            if (state_d == ARB_OWN) begin
                grant_d    = grant_q;
                active_d   = 1'b1;
                owner_d    = owner_q;
                hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HCW'(1);
            end else begin
                timeout_d = owner_hold && hold_expired;
            end
        end
    end

    assign bus_grant   = grant_q;
    assign bus_active  = active_q;
    assign owner_id    = owner_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic       plusclk;
    logic       rst;
    logic [3:0] bus_req;
    logic [3:0] bus_req_type;
    logic [3:0] bus_hold;
    logic [3:0] bus_grant;
    logic       bus_active;
    logic [1:0] owner_id;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    bus_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (16),
        .ID_WIDTH (2)
    ) dut (
        .plusclk      (plusclk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_req_type (bus_req_type),
        .bus_hold     (bus_hold),
        .bus_grant    (bus_grant),
        .bus_active   (bus_active),
        .owner_id     (owner_id),
        .timeout_err  (timeout_err)
    );

    initial plusclk = 1'b0;
    always #5 plusclk = ~plusclk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge plusclk);
    endtask

    // Advance until a new tenure starts (grant rises from zero) or the budget runs out.
    task automatic wait_new_grant(input int budget, output bit ok, output int cycles);
        logic [3:0] prev;
        prev   = bus_grant;
        ok     = 1'b0;
        cycles = 0;
        for (int c = 0; c < budget; c++) begin
            step();
            cycles++;
            if (bus_grant !== 4'b0 && prev === 4'b0) begin
                ok = 1'b1;
                break;
            end
            prev = bus_grant;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus_req      = 4'b0;
        bus_req_type = 4'b0;
        bus_hold     = 4'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", bus_grant); end
        checks++; if (bus_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", bus_active); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        step();
        checks++; if (bus_grant !== 4'b0) begin errors++; $display("FAIL idle_no_req got %b want 0000", bus_grant); end
    endtask

    task automatic test_single();
        logic [3:0] exp;
        int n_act;
        bus_req      = 4'b0001;
        bus_req_type = 4'b0000;
        bus_hold     = 4'b0001;
        exp_q.push_back(4'b0001);
        step();
        exp = exp_q.pop_front();
        checks++; if (bus_grant !== exp) begin errors++; $display("FAIL single_latency got %b want %b", bus_grant, exp); end
        checks++; if (bus_active !== 1'b1) begin errors++; $display("FAIL single_active got %b want 1", bus_active); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL single_owner got %0d want 0", owner_id); end
        bus_req = 4'b0;
        n_act = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (!bus_active) break;
            n_act++;
            bus_hold = (n_act < 4) ? 4'b0001 : 4'b0000;
        end
        checks++; if (n_act !== 4) begin errors++; $display("FAIL single_tenure got %0d want 4", n_act); end
        checks++; if (bus_grant !== 4'b0) begin errors++; $display("FAIL single_turn_grant got %b want 0000", bus_grant); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL single_turn_owner got %0d want 0", owner_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL single_turn_timeout got %b want 0", timeout_err); end
        bus_hold = 4'b0;
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] prev;
        logic [3:0] exp;
        int last;
        int ngrant;
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        bus_req = 4'b1111;
        bus_hold = 4'b0000;
        prev = 4'b0;
        last = 0;
        ngrant = 0;
        for (int cyc = 1; cyc <= 40 && exp_q.size() > 0; cyc++) begin
            step();
            if (bus_grant !== 4'b0 && prev === 4'b0) begin
                exp = exp_q.pop_front();
                checks++; if (bus_grant !== exp) begin errors++; $display("FAIL fair_order got %b want %b", bus_grant, exp); end
                if (ngrant == 0) begin
                    checks++; if (cyc !== 1) begin errors++; $display("FAIL fair_first_latency got %0d want 1", cyc); end
                end else begin
                    checks++; if (cyc - last !== 3) begin errors++; $display("FAIL fair_spacing got %0d want 3", cyc - last); end
                end
                last = cyc;
                ngrant++;
            end
            prev = bus_grant;
        end
        bus_req = 4'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fair_missing got %0d pending want 0", exp_q.size()); end
        exp_q.delete();
        step(); step(); step();
    endtask

    task automatic test_pwb();
        logic [3:0] exp;
        bit ok;
        int cyc;
        do_reset();
        bus_req = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_new_grant(10, ok, cyc);
        bus_req = 4'b0;
        exp = exp_q.pop_front();
        checks++; if (!ok || bus_grant !== exp) begin errors++; $display("FAIL pwb_setup got %b want %b", bus_grant, exp); end
        step();
        // rr_ptr is now 0: a normal scan would pick agent 1.
        bus_req      = 4'b0110;
        bus_req_type = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_new_grant(10, ok, cyc);
        bus_req = 4'b0;
        bus_req_type = 4'b0;
        exp = exp_q.pop_front();
        checks++; if (!ok || bus_grant !== exp) begin errors++; $display("FAIL pwb_priority got %b want %b", bus_grant, exp); end
        checks++; if (owner_id !== 2'd2) begin errors++; $display("FAIL pwb_owner got %0d want 2", owner_id); end
        step();
        // PWB grant moved rr_ptr to 2: normal scan from 3 now finds agent 1.
        bus_req = 4'b0110;
        exp_q.push_back(4'b0010);
        wait_new_grant(10, ok, cyc);
        bus_req = 4'b0;
        exp = exp_q.pop_front();
        checks++; if (!ok || bus_grant !== exp) begin errors++; $display("FAIL pwb_ptr_advance got %b want %b", bus_grant, exp); end
        step(); step(); step();
    endtask

    task automatic test_timeout();
        logic [3:0] exp;
        bit ok;
        int cyc;
        int n_act;
        int n_to;
        bus_req  = 4'b0010;
        bus_hold = 4'b1111;
        exp_q.push_back(4'b0010);
        wait_new_grant(10, ok, cyc);
        bus_req = 4'b0;
        exp = exp_q.pop_front();
        checks++; if (!ok || bus_grant !== exp) begin errors++; $display("FAIL to_grant got %b want %b", bus_grant, exp); end
        n_act = 1;
        n_to = timeout_err ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (!bus_active) break;
            n_act++;
            if (timeout_err) n_to++;
        end
        checks++; if (n_act !== 16) begin errors++; $display("FAIL to_tenure got %0d want 16", n_act); end
        checks++; if (n_to !== 0) begin errors++; $display("FAIL to_early_pulse got %0d want 0", n_to); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", timeout_err); end
        checks++; if (bus_grant !== 4'b0) begin errors++; $display("FAIL to_turn_grant got %b want 0000", bus_grant); end
        bus_hold = 4'b0;
        step();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b want 0", timeout_err); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        bit ok;
        int cyc;
        bus_req  = 4'b1000;
        bus_hold = 4'b1000;
        exp_q.push_back(4'b1000);
        wait_new_grant(10, ok, cyc);
        bus_req = 4'b0;
        exp = exp_q.pop_front();
        checks++; if (!ok || bus_grant !== exp) begin errors++; $display("FAIL rstmid_grant got %b want %b", bus_grant, exp); end
        step(); step();
        checks++; if (owner_id !== 2'd3) begin errors++; $display("FAIL rstmid_owner got %0d want 3", owner_id); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus_grant !== 4'b0) begin errors++; $display("FAIL rstmid_clear_grant got %b want 0000", bus_grant); end
        checks++; if (bus_active !== 1'b0) begin errors++; $display("FAIL rstmid_clear_active got %b want 0", bus_active); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL rstmid_clear_owner got %0d want 0", owner_id); end
        bus_hold = 4'b0;
        bus_req  = 4'b1001;
        exp_q.push_back(4'b0001);
        wait_new_grant(10, ok, cyc);
        bus_req = 4'b0;
        exp = exp_q.pop_front();
        checks++; if (!ok || bus_grant !== exp) begin errors++; $display("FAIL rstmid_ptr got %b want %b", bus_grant, exp); end
        step(); step(); step();
    endtask

    task automatic test_random();
        logic [3:0] prev;
        logic [3:0] prev2;
        logic [3:0] req_drv;
        logic [3:0] g;
        logic [1:0] exp_id;
        prev  = bus_grant;
        prev2 = 4'b0;
        for (int c = 0; c < 10000; c++) begin
            req_drv      = 4'($urandom);
            bus_req      = req_drv;
            bus_req_type = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            bus_hold     = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
            step();
            g = bus_grant;
            exp_id = (g !== 4'b0) ? idx_of(g) : 2'd0;
            checks++; if ((g & (g - 4'd1)) !== 4'b0) begin errors++; $display("FAIL rnd_onehot got %b want onehot or 0000", g); end
            checks++; if (bus_active !== (|g)) begin errors++; $display("FAIL rnd_active got %b want %b", bus_active, |g); end
            checks++; if (owner_id !== exp_id) begin errors++; $display("FAIL rnd_owner got %0d want %0d", owner_id, exp_id); end
            if (prev2 !== 4'b0 && prev === 4'b0) begin
                checks++; if (g !== 4'b0) begin errors++; $display("FAIL rnd_turn_gap got %b want 0000", g); end
            end
            if (g !== 4'b0 && prev === 4'b0) begin
                checks++; if ((g & ~req_drv) !== 4'b0) begin errors++; $display("FAIL rnd_grant_unrequested got %b want subset of %b", g, req_drv); end
            end
            prev2 = prev;
            prev  = g;
        end
        bus_req = 4'b0;
        bus_req_type = 4'b0;
        bus_hold = 4'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus_req      = 4'b0;
        bus_req_type = 4'b0;
        bus_hold     = 4'b0;
        test_reset();
        test_single();
        test_fairness();
        test_pwb();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
